alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu.sv | 34 +++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU constants and arbiter state encoding
package alu_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU selected by funct3/funct7
import alu_arbiter_pkg::*;

module alu (
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic [XLEN-1:0] out,
    output logic            zero
);

    logic [4:0] shamt;
    assign shamt = in2[4:0];

    // funct7 only modifies ADD (-> SUB) and SRL (-> SRA)
    always_comb begin
        out = '0;
        case (funct3)
            F3_ADD:  out = funct7 ? (in1 - in2) : (in1 + in2);
            F3_SLL:  out = in1 << shamt;
            F3_SLT:  out = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            F3_SLTU: out = {{(XLEN-1){1'b0}}, (in1 < in2)};
            F3_XOR:  out = in1 ^ in2;
            F3_SRL:  out = funct7 ? $unsigned($signed(in1) >>> shamt) : (in1 >> shamt);
            F3_OR:   out = in1 | in2;
            F3_AND:  out = in1 & in2;
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
import alu_arbiter_pkg::*;

module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [2:0]      req0_funct3,
    input  logic            req0_funct7,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [2:0]      req1_funct3,
    input  logic            req1_funct7,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic [XLEN-1:0] res_out,
    output logic            res_zero
);

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            res_id_q, res_id_d;
    logic [XLEN-1:0] res_out_q, res_out_d;
    logic            res_zero_q, res_zero_d;

    logic            can_accept;
    logic            grant;
    logic            grant_id;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
    logic [2:0]      alu_funct3;
    logic            alu_funct7, alu_zero;

    // grant selection: the priority holder wins a tie, a lone requester always wins
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || res_ready;
        grant      = can_accept && (req0_valid || req1_valid);
        grant_id   = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = rst_n && grant && !grant_id;
        req1_ready = rst_n && grant &&  grant_id;
    end

    // operand mux feeding the single shared ALU
    always_comb begin
        alu_in1    = grant_id ? req1_in1    : req0_in1;
        alu_in2    = grant_id ? req1_in2    : req0_in2;
        alu_funct3 = grant_id ? req1_funct3 : req0_funct3;
        alu_funct7 = grant_id ? req1_funct7 : req0_funct7;
    end

    alu u_alu (
        .in1    (alu_in1),
        .in2    (alu_in2),
        .funct3 (alu_funct3),
        .funct7 (alu_funct7),
        .out    (alu_out),
        .zero   (alu_zero)
    );

    // next-state: refill on grant, drain to EMPTY when consumed with nothing new
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        res_id_d   = res_id_q;
        res_out_d  = res_out_q;
        res_zero_d = res_zero_q;
        if (grant) begin
            state_d    = ST_FULL;
            prio_d     = !grant_id;
            res_id_d   = grant_id;
            res_out_d  = alu_out;
            res_zero_d = alu_zero;
        end else if (state_q == ST_FULL && res_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // result register and priority pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            prio_q     <= RR_INIT;
            res_id_q   <= 1'b0;
            res_out_q  <= '0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            res_id_q   <= res_id_d;
            res_out_q  <= res_out_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_id    = res_id_q;
    assign res_out   = res_out_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a reference model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  f30, f31;
    logic        f70, f71;
    logic        res_valid, res_ready, res_id, res_zero;
    logic [31:0] res_out;

    int vectors     = 0;
    int miscompares = 0;

    logic        m_full, m_id, m_zero, m_prio;
    logic [31:0] m_out;
    logic        last_r0, last_r1;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (v0),
        .req0_ready  (r0),
        .req0_in1    (a0),
        .req0_in2    (b0),
        .req0_funct3 (f30),
        .req0_funct7 (f70),
        .req1_valid  (v1),
        .req1_ready  (r1),
        .req1_in1    (a1),
        .req1_in2    (b1),
        .req1_funct3 (f31),
        .req1_funct7 (f71),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_out     (res_out),
        .res_zero    (res_zero)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] f3, input logic f7);
        int unsigned sh;
        logic [31:0] r;
        sh = y % 32;
        case (f3)
            3'd0: r = f7 ? x - y : x + y;
            3'd1: r = x << sh;
            3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: r = (x < y) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: begin
                r = x >> sh;
                if (f7 && x[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = x | y;
            default: r = x & y;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: check the combinational grant, then the registered result
    task automatic step();
        logic acc, g, any;
        logic [31:0] r;
        #2;
        any = v0 || v1;
        acc = rst_n && (!m_full || res_ready) && any;
        g   = (v0 && v1) ? m_prio : v1;
        last_r0 = r0;
        last_r1 = r1;
        chk("req0_ready", {31'b0, r0}, {31'b0, acc && !g});
        chk("req1_ready", {31'b0, r1}, {31'b0, acc && g});
        r = g ? alu_ref(a1, b1, f31, f71) : alu_ref(a0, b0, f30, f70);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_full = 0; m_out = 0; m_zero = 0; m_id = 0; m_prio = 1'b0;
        end else if (acc) begin
            m_full = 1; m_out = r; m_zero = (r == 0); m_id = g; m_prio = !g;
        end else if (m_full && res_ready) begin
            m_full = 0;
        end
        chk("res_valid", {31'b0, res_valid}, {31'b0, m_full});
        if (m_full || !rst_n) begin
            chk("res_out", res_out, m_out);
            chk("res_zero", {31'b0, res_zero}, {31'b0, m_zero});
            chk("res_id", {31'b0, res_id}, {31'b0, m_id});
        end
    endtask

    task automatic idle();
        v0 = 0; v1 = 0;
        a0 = 0; b0 = 0; f30 = 0; f70 = 0;
        a1 = 0; b1 = 0; f31 = 0; f71 = 0;
    endtask

    initial begin
        m_full = 0; m_out = 0; m_zero = 0; m_id = 0; m_prio = 0;
        idle();
        res_ready = 1;
        rst_n = 0;
        v0 = 1;
        step();
        chk("reset_ready0", {31'b0, last_r0}, 32'd0);
        chk("reset_out", res_out, 32'd0);
        rst_n = 1;
        idle();

        // lone requester 0 ADD
        v0 = 1; a0 = 32'h0000_0AC3; b0 = 32'h0000_011F; f30 = 3'd0; f70 = 0;
        step();
        chk("add_ready0", {31'b0, last_r0}, 32'd1);
        chk("add_out", res_out, 32'h0000_0BE2);
        chk("add_id", {31'b0, res_id}, 32'd0);
        idle();

        // lone requester 1 SUB, then SUB to zero
        v1 = 1; a1 = 32'h0000_0AC3; b1 = 32'h0000_011F; f31 = 3'd0; f71 = 1;
        step();
        chk("sub_out", res_out, 32'h0000_09A4);
        chk("sub_id", {31'b0, res_id}, 32'd1);
        a1 = 32'h1234; b1 = 32'h1234;
        step();
        chk("sub_zero_out", res_out, 32'd0);
        chk("sub_zero_flag", {31'b0, res_zero}, 32'd1);
        idle();
        step();

        // round robin SRL / SRA after fresh reset
        rst_n = 0;
        step();
        rst_n = 1;
        v0 = 1; a0 = 32'hA100_0015; b0 = 32'd2; f30 = 3'd5; f70 = 0;
        v1 = 1; a1 = 32'hA100_0015; b1 = 32'd2; f31 = 3'd5; f71 = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_id", {31'b0, res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_out", res_out, (i % 2 == 0) ? 32'h2840_0005 : 32'hE840_0005);
        end

        // backpressure while FULL, then priority holder granted on release
        res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_out", res_out, 32'hE840_0005);
        end
        res_ready = 1;
        step();
        chk("release_ready0", {31'b0, last_r0}, 32'd1);
        chk("release_ready1", {31'b0, last_r1}, 32'd0);

        // reset while FULL discards result and restores priority
        rst_n = 0;
        step();
        chk("rst_full_ready1", {31'b0, last_r1}, 32'd0);
        chk("rst_full_valid", {31'b0, res_valid}, 32'd0);
        rst_n = 1;
        step();
        chk("post_rst_grant0", {31'b0, last_r0}, 32'd1);
        chk("post_rst_out", res_out, 32'h2840_0005);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            a0 = $urandom; b0 = ($urandom_range(0, 5) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 5) == 0) ? a1 : $urandom;
            f30 = 3'($urandom_range(0, 7)); f70 = 1'($urandom_range(0, 1));
            f31 = 3'($urandom_range(0, 7)); f71 = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
